// File: rtl/i2c_codec_regslave.sv
// I2C write-only target that models the WM8731 control port.
// Takes 3-byte frames {dev+W, {reg[6:0],d8}, d[7:0]}, ACKs them and commits
// the 9-bit value into a small register file used by the audio path.
module i2c_codec_regslave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h1A,
  parameter int         NUM_REGS   = 10
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iSCL,
  input  logic       iSDA,
  output logic       oSDA_OE,
  output logic       oBUSY,
  output logic       oREG_WE,
  output logic [6:0] oREG_ADDR,
  output logic [8:0] oREG_DATA,
  input  logic [3:0] iRD_ADDR,
  output logic [8:0] oRD_DATA,
  output logic       oACTIVE,
  output logic       oCODEC_RST
);

  localparam int         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [6:0] NUM_REGS_A = 7'(NUM_REGS);
  localparam logic [4:0] NUM_REGS_R = 5'(NUM_REGS);
  localparam logic [6:0] RESET_REG  = 7'h0F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ACK_A,
    S_BYTE1,
    S_ACK_1,
    S_BYTE2,
    S_ACK_2,
    S_IGNORE
  } state_t;

  // Power-on contents of the codec registers; unlisted entries start at zero.
  function automatic logic [8:0] regDefault(input int idx);
    case (idx)
      0:       regDefault = 9'h097;
      1:       regDefault = 9'h097;
      2:       regDefault = 9'h079;
      3:       regDefault = 9'h079;
      4:       regDefault = 9'h00A;
      5:       regDefault = 9'h008;
      6:       regDefault = 9'h09F;
      7:       regDefault = 9'h00A;
      default: regDefault = 9'h000;
    endcase
  endfunction

  logic [1:0] r_sclSync;
  logic [1:0] r_sdaSync;
  logic       r_sclPrev;
  logic       r_sdaPrev;

  logic       w_scl;
  logic       w_sda;
  logic       w_sclRise;
  logic       w_sclFall;
  logic       w_start;
  logic       w_stop;

  state_t     r_state;
  state_t     w_stateNext;

  logic [3:0] r_bitCnt;
  logic [7:0] r_shift;
  logic       r_ackClk;
  logic [6:0] r_regAddr;
  logic       r_d8;

  logic       w_byteDone;
  logic       w_addrMatch;
  logic       w_shiftEn;
  logic       w_frameClr;
  logic       w_cntClr;
  logic       w_oeSet;
  logic       w_oeClr;
  logic       w_latchReg;
  logic       w_commit;
  logic       w_ackClkSet;
  logic       w_busySet;
  logic       w_busyClr;

  logic [8:0] r_regs [0:NUM_REGS-1];

  // Bring SCL/SDA into the iCLK domain and keep the previous sample for edge decode.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sclSync <= 2'b11;
      r_sdaSync <= 2'b11;
      r_sclPrev <= 1'b1;
      r_sdaPrev <= 1'b1;
    end else begin
      r_sclSync <= {r_sclSync[0], iSCL};
      r_sdaSync <= {r_sdaSync[0], iSDA};
      r_sclPrev <= r_sclSync[1];
      r_sdaPrev <= r_sdaSync[1];
    end
  end

  assign w_scl       = r_sclSync[1];
  assign w_sda       = r_sdaSync[1];
  assign w_sclRise   = w_scl & ~r_sclPrev;
  assign w_sclFall   = ~w_scl & r_sclPrev;
  assign w_start     = w_scl & r_sclPrev & r_sdaPrev & ~w_sda;
  assign w_stop      = w_scl & r_sclPrev & ~r_sdaPrev & w_sda;
  assign w_byteDone  = (r_bitCnt == 4'd8);
  assign w_addrMatch = (r_shift == {SLAVE_ADDR, 1'b0});

  // Protocol state register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state and per-cycle control strobes; bus conditions outrank bit handling.
  always_comb begin
    w_stateNext = r_state;
    w_shiftEn   = 1'b0;
    w_frameClr  = 1'b0;
    w_cntClr    = 1'b0;
    w_oeSet     = 1'b0;
    w_oeClr     = 1'b0;
    w_latchReg  = 1'b0;
    w_commit    = 1'b0;
    w_ackClkSet = 1'b0;
    w_busySet   = 1'b0;
    w_busyClr   = 1'b0;
    if (w_start) begin
      w_stateNext = S_ADDR;
      w_frameClr  = 1'b1;
      w_oeClr     = 1'b1;
      w_busySet   = 1'b1;
    end else if (w_stop) begin
      w_stateNext = S_IDLE;
      w_oeClr     = 1'b1;
      w_busyClr   = 1'b1;
    end else begin
      case (r_state)
        S_ADDR, S_BYTE1, S_BYTE2: begin
          if (w_sclRise && !w_byteDone) begin
            w_shiftEn = 1'b1;
          end else if (w_sclFall && w_byteDone) begin
            w_cntClr = 1'b1;
            if (r_state == S_ADDR) begin
              if (w_addrMatch) begin
                w_oeSet     = 1'b1;
                w_stateNext = S_ACK_A;
              end else begin
                w_stateNext = S_IGNORE;
              end
            end else if (r_state == S_BYTE1) begin
              w_latchReg  = 1'b1;
              w_oeSet     = 1'b1;
              w_stateNext = S_ACK_1;
            end else begin
              w_commit    = 1'b1;
              w_oeSet     = 1'b1;
              w_stateNext = S_ACK_2;
            end
          end
        end
        S_ACK_A, S_ACK_1, S_ACK_2: begin
          if (w_sclRise) begin
            w_ackClkSet = 1'b1;
          end else if (w_sclFall && r_ackClk) begin
            w_oeClr  = 1'b1;
            w_cntClr = 1'b1;
            if (r_state == S_ACK_A) begin
              w_stateNext = S_BYTE1;
            end else if (r_state == S_ACK_1) begin
              w_stateNext = S_BYTE2;
            end else begin
              w_stateNext = S_IGNORE;
            end
          end
        end
        S_IGNORE: begin
          w_oeClr = 1'b1;
        end
        default: begin
          w_stateNext = r_state;
        end
      endcase
    end
  end

  // Bit counter, shift register, ACK-clock tracking and register-address latch.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_bitCnt  <= 4'd0;
      r_shift   <= 8'd0;
      r_ackClk  <= 1'b0;
      r_regAddr <= 7'd0;
      r_d8      <= 1'b0;
    end else begin
      if (w_frameClr) begin
        r_bitCnt <= 4'd0;
        r_shift  <= 8'd0;
      end else if (w_cntClr) begin
        r_bitCnt <= 4'd0;
      end else if (w_shiftEn) begin
        r_shift  <= {r_shift[6:0], w_sda};
        r_bitCnt <= r_bitCnt + 4'd1;
      end
      if (w_stateNext != r_state) begin
        r_ackClk <= 1'b0;
      end else if (w_ackClkSet) begin
        r_ackClk <= 1'b1;
      end
      if (w_latchReg) begin
        r_regAddr <= r_shift[7:1];
        r_d8      <= r_shift[0];
      end
    end
  end

  // Registered bus-facing and audio-path-facing outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oSDA_OE    <= 1'b0;
      oBUSY      <= 1'b0;
      oREG_WE    <= 1'b0;
      oREG_ADDR  <= 7'd0;
      oREG_DATA  <= 9'd0;
      oCODEC_RST <= 1'b0;
    end else begin
      oREG_WE    <= 1'b0;
      oCODEC_RST <= 1'b0;
      if (w_oeClr) begin
        oSDA_OE <= 1'b0;
      end else if (w_oeSet) begin
        oSDA_OE <= 1'b1;
      end
      if (w_busySet) begin
        oBUSY <= 1'b1;
      end else if (w_busyClr) begin
        oBUSY <= 1'b0;
      end
      if (w_commit) begin
        oREG_WE   <= 1'b1;
        oREG_ADDR <= r_regAddr;
        oREG_DATA <= {r_d8, r_shift};
        if (r_regAddr == RESET_REG) begin
          oCODEC_RST <= 1'b1;
        end
      end
    end
  end

  // Register file: commits write one entry, a write to the reset register restores all.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= regDefault(i);
      end
    end else if (w_commit) begin
      if (r_regAddr < NUM_REGS_A) begin
        r_regs[r_regAddr[IDX_W-1:0]] <= {r_d8, r_shift};
      end else if (r_regAddr == RESET_REG) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          r_regs[i] <= regDefault(i);
        end
      end
    end
  end

  // Registered read port; addresses past the implemented registers read as zero.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oRD_DATA <= 9'd0;
    end else if ({1'b0, iRD_ADDR} < NUM_REGS_R) begin
      oRD_DATA <= r_regs[iRD_ADDR[IDX_W-1:0]];
    end else begin
      oRD_DATA <= 9'd0;
    end
  end

  generate
    if (NUM_REGS > 9) begin : g_active
      assign oACTIVE = r_regs[9][0];
    end else begin : g_noActive
      assign oACTIVE = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_i2c_codec_regslave.sv
// Bench for i2c_codec_regslave: a bit-banged I2C master drives frames while a
// frame-level model predicts ACKs, commits and register contents.
module tb_i2c_codec_regslave;

  localparam int Q = 6;

  typedef struct {
    logic [6:0] addr;
    logic [8:0] data;
    logic       rst;
  } commit_t;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic       sclM = 1'b1;
  logic       sdaM = 1'b1;
  logic [3:0] rdAddr = 4'd0;
  logic       sdaBus;
  logic       sdaOe;
  logic       busy;
  logic       regWe;
  logic [6:0] regAddr;
  logic [8:0] regData;
  logic [8:0] rdData;
  logic       active;
  logic       codecRst;

  int checks = 0;
  int errors = 0;
  int weCount = 0;
  int rstCount = 0;
  bit allowOe = 1'b0;
  bit quiet = 1'b0;

  logic [8:0] modelRegs [0:9];
  commit_t    expQ [$];

  assign sdaBus = sdaM & ~sdaOe;

  always #5 iCLK = ~iCLK;

  i2c_codec_regslave #(.SLAVE_ADDR(7'h1A), .NUM_REGS(10)) dut (
    .iCLK(iCLK),
    .iRST_N(iRST_N),
    .iSCL(sclM),
    .iSDA(sdaBus),
    .oSDA_OE(sdaOe),
    .oBUSY(busy),
    .oREG_WE(regWe),
    .oREG_ADDR(regAddr),
    .oREG_DATA(regData),
    .iRD_ADDR(rdAddr),
    .oRD_DATA(rdData),
    .oACTIVE(active),
    .oCODEC_RST(codecRst)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    logic [8:0] defs [0:9];
    defs = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
    for (int i = 0; i < 10; i++) modelRegs[i] = defs[i];
  endtask

  task automatic modelCommit(input logic [6:0] a, input logic [8:0] d);
    if (a < 7'd10) modelRegs[a[3:0]] = d;
    else if (a == 7'h0F) modelReset();
  endtask

  function automatic logic [8:0] modelRead(input logic [3:0] a);
    return (a < 4'd10) ? modelRegs[a] : 9'h000;
  endfunction

  task automatic waitQ(input int n = 1);
    repeat (n * Q) @(negedge iCLK);
  endtask

  task automatic i2cStart();
    sdaM = 1'b1; waitQ();
    sclM = 1'b1; waitQ();
    sdaM = 1'b0; waitQ();
    sclM = 1'b0; waitQ();
  endtask

  task automatic i2cStop();
    sdaM = 1'b0; waitQ();
    sclM = 1'b1; waitQ();
    sdaM = 1'b1; waitQ();
  endtask

  task automatic writeBits(input logic [7:0] b, input bit expAck);
    for (int i = 7; i >= 0; i--) begin
      sdaM = b[i]; waitQ();
      sclM = 1'b1; waitQ(2);
      if (i == 0) allowOe = expAck;
      sclM = 1'b0; waitQ();
    end
  endtask

  task automatic ackPhase(output logic got);
    sdaM = 1'b1; waitQ();
    sclM = 1'b1; waitQ();
    got = ~sdaBus; waitQ();
    sclM = 1'b0; waitQ();
    allowOe = 1'b0;
  endtask

  task automatic readReg(input logic [3:0] a, output logic [8:0] d);
    @(negedge iCLK) rdAddr = a;
    @(posedge iCLK) #2 d = rdData;
  endtask

  task automatic endFrame();
    i2cStop();
    repeat (8) @(negedge iCLK);
    checkOutput("pendingCommits", expQ.size(), 0);
    quiet = 1'b1;
    repeat (12) @(negedge iCLK) rdAddr = 4'($urandom_range(0, 15));
    @(negedge iCLK);
  endtask

  // Drives one frame of n bytes and predicts ACKs and the commit from frame-level rules.
  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input logic [7:0] b3, input int n, input bit endStop,
                               output logic [3:0] ackMask);
    logic [7:0] bytes [0:3];
    logic got;
    bit addrOk, commits, expAck;
    bytes = '{b0, b1, b2, b3};
    quiet = 1'b0;
    @(negedge iCLK);
    i2cStart();
    addrOk = (b0 == 8'h34);
    commits = addrOk && (n >= 3);
    if (commits) expQ.push_back('{b1[7:1], {b1[0], b2}, (b1[7:1] == 7'h0F)});
    ackMask = 4'b0000;
    for (int i = 0; i < n; i++) begin
      expAck = addrOk && (i < 3);
      writeBits(bytes[i], expAck);
      ackPhase(got);
      ackMask[i] = got;
      checkOutput($sformatf("ack byte%0d of %h", i, b0), got, expAck);
    end
    if (commits) modelCommit(b1[7:1], {b1[0], b2});
    if (endStop) endFrame();
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  initial begin
    commit_t c;
    forever begin
      @(posedge iCLK);
      #2;
      if (!iRST_N) begin
        checkOutput("rst sdaOe", sdaOe, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst regWe", regWe, 0);
        checkOutput("rst regAddr", regAddr, 0);
        checkOutput("rst regData", regData, 0);
        checkOutput("rst rdData", rdData, 0);
        checkOutput("rst codecRst", codecRst, 0);
        checkOutput("rst active", active, 0);
      end else begin
        if (sdaOe) checkOutput("sdaOe allowed", allowOe, 1);
        if (codecRst) begin
          rstCount++;
          checkOutput("codecRst with regWe", regWe, 1);
        end
        if (regWe) begin
          weCount++;
          checkOutput("commit expected", expQ.size() > 0, 1);
          if (expQ.size() > 0) begin
            c = expQ.pop_front();
            checkOutput("commit addr", regAddr, c.addr);
            checkOutput("commit data", regData, c.data);
            checkOutput("commit codecRst", codecRst, c.rst);
          end
        end
        if (quiet) begin
          checkOutput($sformatf("rdData[%0d]", rdAddr), rdData, modelRead(rdAddr));
          checkOutput("active", active, modelRegs[9][0]);
          checkOutput("busy idle", busy, 0);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  // Directed test plan followed by randomized frames.
  initial begin
    logic [3:0] acks;
    logic [8:0] d;
    int weBase, rstBase;
    logic [6:0] rnd;
    modelReset();
    repeat (5) @(negedge iCLK);
    iRST_N = 1'b1;
    quiet = 1'b1;
    repeat (6) @(negedge iCLK);
    readReg(4'd0, d); checkOutput("R0 default", d, 9'h097);
    readReg(4'd4, d); checkOutput("R4 default", d, 9'h00A);
    readReg(4'd12, d); checkOutput("R12 unimplemented", d, 9'h000);

    $display("[TB] wrong device address");
    weBase = weCount;
    applyStimulus(8'h36, 8'h00, 8'h1A, 8'h00, 3, 1'b1, acks);
    checkOutput("wrongAddr acks", acks, 4'b0000);
    readReg(4'd0, d); checkOutput("R0 after wrongAddr", d, 9'h097);
    checkOutput("wrongAddr no commit", weCount - weBase, 0);

    $display("[TB] config sequence");
    weBase = weCount;
    applyStimulus(8'h34, 8'h00, 8'h1A, 8'h00, 3, 1'b1, acks);
    checkOutput("cfg1 acks", acks, 4'b0111);
    applyStimulus(8'h34, 8'h12, 8'h01, 8'h00, 3, 1'b1, acks);
    checkOutput("cfg2 acks", acks, 4'b0111);
    readReg(4'd0, d); checkOutput("R0 after cfg", d, 9'h01A);
    checkOutput("model R0 after cfg", modelRegs[0], 9'h01A);
    checkOutput("active after cfg", active, 1);
    checkOutput("cfg commit count", weCount - weBase, 2);

    $display("[TB] reset register write");
    rstBase = rstCount;
    applyStimulus(8'h34, 8'h1E, 8'h00, 8'h00, 3, 1'b1, acks);
    checkOutput("codecRst pulses", rstCount - rstBase, 1);
    readReg(4'd0, d); checkOutput("R0 after R15", d, 9'h097);
    checkOutput("active after R15", active, 0);
    checkOutput("model R9 after R15", modelRegs[9], 9'h000);

    $display("[TB] aborted frame");
    weBase = weCount;
    applyStimulus(8'h34, 8'h08, 8'h00, 8'h00, 2, 1'b1, acks);
    checkOutput("abort acks", acks, 4'b0011);
    checkOutput("abort no commit", weCount - weBase, 0);
    readReg(4'd4, d); checkOutput("R4 after abort", d, 9'h00A);
    applyStimulus(8'h34, 8'h08, 8'hF8, 8'h00, 3, 1'b1, acks);
    readReg(4'd4, d); checkOutput("R4 after full frame", d, 9'h0F8);

    $display("[TB] overrun and read request");
    applyStimulus(8'h34, 8'h0A, 8'h06, 8'h55, 4, 1'b1, acks);
    checkOutput("overrun acks", acks, 4'b0111);
    readReg(4'd5, d); checkOutput("R5 after overrun", d, 9'h006);
    applyStimulus(8'h35, 8'h00, 8'h00, 8'h00, 1, 1'b0, acks);
    checkOutput("readReq ack", acks, 4'b0000);
    repeat (10) @(negedge iCLK);
    checkOutput("readReq busy", busy, 1);
    endFrame();

    $display("[TB] reset during BYTE2 ACK");
    quiet = 1'b0;
    i2cStart();
    expQ.push_back('{7'h09, 9'h001, 1'b0});
    writeBits(8'h34, 1'b1); ackPhase(acks[0]);
    writeBits(8'h12, 1'b1); ackPhase(acks[1]);
    checkOutput("rstTest acks", acks[1:0], 2'b11);
    writeBits(8'h01, 1'b1);
    sdaM = 1'b1; waitQ();
    sclM = 1'b1; waitQ();
    checkOutput("ack held before reset", sdaOe, 1);
    @(negedge iCLK) iRST_N = 1'b0;
    #1 checkOutput("sdaOe async reset", sdaOe, 0);
    modelReset();
    repeat (4) @(negedge iCLK);
    checkOutput("rstTest commit seen", expQ.size(), 0);
    sclM = 1'b0;
    allowOe = 1'b0;
    waitQ();
    iRST_N = 1'b1;
    waitQ();
    i2cStop();
    repeat (8) @(negedge iCLK);
    quiet = 1'b1;
    readReg(4'd9, d); checkOutput("R9 after reset", d, 9'h000);
    readReg(4'd0, d); checkOutput("R0 after reset", d, 9'h097);
    applyStimulus(8'h34, 8'h0E, 8'h01, 8'h00, 3, 1'b1, acks);
    readReg(4'd7, d); checkOutput("R7 after reset frame", d, 9'h001);

    $display("[TB] randomized frames");
    for (int f = 0; f < 25; f++) begin
      logic [7:0] b0, b1;
      int r;
      b0 = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h34;
      r = $urandom_range(0, 15);
      if (r < 10) rnd = 7'(r);
      else if (r == 10) rnd = 7'h0F;
      else rnd = 7'($urandom_range(16, 127));
      b1 = {rnd, 1'($urandom)};
      applyStimulus(b0, b1, 8'($urandom), 8'($urandom), $urandom_range(1, 4),
                    (f == 24) || ($urandom_range(0, 2) != 0), acks);
    end
    for (int i = 0; i < 16; i++) begin
      readReg(4'(i), d);
      checkOutput($sformatf("final R%0d", i), d, modelRead(4'(i)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
